// File: rtl/pc_rx_dispatch.sv
// Pops PC-rx frame descriptors, wins the frame BRAM and streams payload bytes to a type-selected channel.
// Optional statistics counters are built when PC_RX_DISPATCH_STAT_EN is defined.
module pc_rx_dispatch #(
  parameter int U_DLY    = 1,
  parameter int AW       = 12,
  parameter int CH_NUM   = 4,
  parameter int HDR_SKIP = 3,
  parameter int TRL_LEN  = 13,
  parameter int ACK_TMO  = 1024,
  parameter int MAX_LEN  = 4096
) (
  input  logic                   clk_sys,
  input  logic                   rst_n,
  output logic                   fififo_rd_en,
  input  logic [71:0]            fififo_rd_data,
  input  logic                   fififo_empty,
  output logic                   fdram_rd_req,
  input  logic                   fdram_rd_ack,
  output logic                   fdram_rd_done,
  output logic [AW-1:0]          fdram_rd_addr,
  input  logic [7:0]             fdram_rd_data,
  input  logic [16*CH_NUM-1:0]   ch_type_tbl,
  input  logic [CH_NUM-1:0]      ch_type_en,
  output logic [7:0]             out_data,
  output logic [CH_NUM-1:0]      out_valid,
  output logic                   out_sof,
  output logic                   out_eof,
  output logic                   err_len,
  output logic                   err_type,
  output logic                   err_tmo,
  output logic [15:0]            frame_cnt,
  output logic [15:0]            drop_cnt
);

  localparam logic [31:0] MIN_L    = 32'(TRL_LEN + HDR_SKIP + 1);
  localparam logic [31:0] MAX_L    = 32'(MAX_LEN);
  localparam logic [31:0] TRL_L    = 32'(TRL_LEN);
  localparam logic [31:0] HSKIP    = 32'(HDR_SKIP);
  localparam logic [31:0] TMO_LAST = 32'(ACK_TMO - 1);

  typedef enum logic [2:0] {IDLE, POP, CHK, REQ, RD, DONE} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [31:0]         n_q, n_d;
  logic [CH_NUM-1:0]   ch_q, ch_d;
  logic [31:0]         wcnt_q, wcnt_d;
  logic [31:0]         rcnt_q, rcnt_d;
  logic                dcnt_q, dcnt_d;
  logic                err_len_d, err_type_d, err_tmo_d;
  logic                err_len_q, err_type_q, err_tmo_q;
  logic                fwd_d, sof_d, eof_d;
  logic                fwd_p1_q, sof_p1_q, eof_p1_q;
  logic [7:0]          out_data_q;
  logic [CH_NUM-1:0]   out_valid_q;
  logic                out_sof_q, out_eof_q;

  logic [15:0]         desc_type;
  logic [AW-1:0]       desc_addr;
  logic [31:0]         desc_len;
  logic                len_bad;
  logic [CH_NUM-1:0]   match_oh;
  logic                desc_unused;
  logic [31:0]         dly_unused;

  assign desc_type   = fififo_rd_data[71:56];
  assign desc_addr   = fififo_rd_data[40+AW-1:40];
  assign desc_len    = fififo_rd_data[31:0];
  assign len_bad     = (desc_len < MIN_L) || (desc_len > MAX_L);
  assign desc_unused = ^fififo_rd_data;
  assign dly_unused  = 32'(U_DLY);

  // Descending scan so the lowest matching entry is the one left standing.
  always_comb begin
    match_oh = '0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      if (ch_type_en[k] && (ch_type_tbl[16*k +: 16] == desc_type)) begin
        match_oh    = '0;
        match_oh[k] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    n_d           = n_q;
    ch_d          = ch_q;
    wcnt_d        = wcnt_q;
    rcnt_d        = rcnt_q;
    dcnt_d        = dcnt_q;
    err_len_d     = 1'b0;
    err_type_d    = 1'b0;
    err_tmo_d     = 1'b0;
    fwd_d         = 1'b0;
    sof_d         = 1'b0;
    eof_d         = 1'b0;
    fififo_rd_en  = 1'b0;
    fdram_rd_req  = 1'b0;
    fdram_rd_done = 1'b0;
    case (state_q)
      IDLE: if (!fififo_empty) state_d = POP;
      POP: begin
        if (!fififo_empty) begin
          fififo_rd_en = 1'b1;
          state_d      = CHK;
        end else begin
          state_d = IDLE;
        end
      end
      CHK: begin
        addr_d = desc_addr;
        n_d    = desc_len - TRL_L;
        ch_d   = match_oh;
        wcnt_d = '0;
        rcnt_d = '0;
        dcnt_d = 1'b0;
        if (len_bad) begin
          err_len_d = 1'b1;
          state_d   = IDLE;
        end else if (match_oh == '0) begin
          err_type_d = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = REQ;
        end
      end
      REQ: begin
        fdram_rd_req = 1'b1;
        if (fdram_rd_ack) begin
          state_d = RD;
        end else if (wcnt_q == TMO_LAST) begin
          err_tmo_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wcnt_d = wcnt_q + 32'd1;
        end
      end
      RD: begin
        fwd_d  = (rcnt_q >= HSKIP);
        sof_d  = (rcnt_q == HSKIP);
        eof_d  = (rcnt_q == n_q - 32'd1);
        addr_d = addr_q + 1'b1;
        rcnt_d = rcnt_q + 32'd1;
        if (rcnt_q == n_q - 32'd1) state_d = DONE;
      end
      // Two cycles: BRAM latency plus output register, so done lines up with the last byte.
      DONE: begin
        dcnt_d = 1'b1;
        if (dcnt_q) begin
          fdram_rd_done = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      n_q         <= '0;
      ch_q        <= '0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      dcnt_q      <= 1'b0;
      err_len_q   <= 1'b0;
      err_type_q  <= 1'b0;
      err_tmo_q   <= 1'b0;
      fwd_p1_q    <= 1'b0;
      sof_p1_q    <= 1'b0;
      eof_p1_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= '0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      n_q         <= n_d;
      ch_q        <= ch_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      dcnt_q      <= dcnt_d;
      err_len_q   <= err_len_d;
      err_type_q  <= err_type_d;
      err_tmo_q   <= err_tmo_d;
      fwd_p1_q    <= fwd_d;
      sof_p1_q    <= sof_d;
      eof_p1_q    <= eof_d;
      if (fwd_p1_q) out_data_q <= fdram_rd_data;
      out_valid_q <= fwd_p1_q ? ch_q : '0;
      out_sof_q   <= fwd_p1_q & sof_p1_q;
      out_eof_q   <= fwd_p1_q & eof_p1_q;
    end
  end

  assign fdram_rd_addr = addr_q;
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_sof       = out_sof_q;
  assign out_eof       = out_eof_q;
  assign err_len       = err_len_q;
  assign err_type      = err_type_q;
  assign err_tmo       = err_tmo_q;

`ifdef PC_RX_DISPATCH_STAT_EN
  logic [15:0] frame_cnt_q, drop_cnt_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (out_eof_q && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 16'd1;
      if ((err_len_q | err_type_q | err_tmo_q) && (drop_cnt_q != 16'hFFFF))
        drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`else
  assign frame_cnt = '0;
  assign drop_cnt  = '0;
`endif

endmodule

// File: doc/pc_rx_dispatch.md
Name: pc_rx_dispatch

Overview:
Parametrised successor to the PC receive config block. It pops frame descriptors from the frame info FIFO and arbitrates for the frame-data BRAM read port. It then streams each frame's payload bytes to one of CH_NUM output channels, selected by a runtime type-match table. It adds length checking, an ack timeout, unmatched-type drop and statistics, and sits between the PC rx framer (BRAM + info FIFO) and the SLR/upconvert/memory/inter-config consumers.

Parameters:
U_DLY, 1, register assignment delay (ns) for simulation
AW, 12, BRAM address width (1..16); descriptor start address is fififo_rd_data[40+AW-1:40]
CH_NUM, 4, number of output channels (1..8)
HDR_SKIP, 3, leading bytes read but not forwarded
TRL_LEN, 13, trailing bytes of frame length never read (CRC/tail)
ACK_TMO, 1024, max cycles waiting for fdram_rd_ack
MAX_LEN, 4096, largest legal frame length in bytes

Ports:
clk_sys  in  1  system clock
rst_n  in  1  asynchronous active-low reset
fififo_rd_en  out  1  info FIFO pop, one-cycle pulse
fififo_rd_data  in  72  descriptor: [71:56] type, [40+AW-1:40] start addr, [31:0] frame length; valid the cycle after pop
fififo_empty  in  1  info FIFO empty
fdram_rd_req  out  1  BRAM access request, level
fdram_rd_ack  in  1  BRAM access grant, pulse or level
fdram_rd_done  out  1  release BRAM, one-cycle pulse
fdram_rd_addr  out  AW  BRAM read address
fdram_rd_data  in  8  BRAM data, 1-cycle read latency
ch_type_tbl  in  16*CH_NUM  channel k matches type ch_type_tbl[16k+:16]
ch_type_en  in  CH_NUM  per-channel table entry enable
out_data  out  8  payload byte
out_valid  out  CH_NUM  one-hot byte strobe
out_sof  out  1  first forwarded byte of frame, coincident with out_valid
out_eof  out  1  last forwarded byte of frame, coincident with out_valid
err_len  out  1  pulse: illegal length, frame dropped
err_type  out  1  pulse: no channel matched, frame dropped
err_tmo  out  1  pulse: ack timeout, frame dropped
frame_cnt  out  16  frames forwarded (STAT_EN)
drop_cnt  out  16  frames dropped (STAT_EN)

Behaviour:
- Reset: all outputs 0, FSM in IDLE, internal counters 0. Asynchronous reset at any point aborts the frame immediately; req is not held.
- FSM: IDLE -> POP -> CHK -> REQ -> RD -> DONE -> IDLE.
- IDLE: if !fififo_empty, go to POP. POP: fififo_rd_en=1 for exactly one cycle.
- CHK: latch the descriptor (type, addr, len). Let N = len - TRL_LEN, computed as 32-bit.
- CHK length check: if len < TRL_LEN+HDR_SKIP+1 or len > MAX_LEN, pulse err_len and return to IDLE. No BRAM request is made.
- CHK type match: otherwise match type against enabled table entries; lowest matching index wins. If there is no match, pulse err_type and return to IDLE. Otherwise go to REQ.
- REQ: assert fdram_rd_req and count wait cycles. The cycle ack is seen, drop req and enter RD with fdram_rd_addr = start.
- REQ timeout: if the wait count reaches ACK_TMO first, drop req, pulse err_tmo, and return to IDLE.
- RD: drive addresses start..start+N-1, one per cycle, wrapping modulo 2^AW.
- Data path: byte i is registered onto out_data 2 cycles after its address. Bytes i = HDR_SKIP..N-1 assert out_valid[ch]. out_sof marks i=HDR_SKIP and out_eof marks i=N-1; both are set on one byte when N-HDR_SKIP=1.
- DONE: entered after the last address. Pulse fdram_rd_done in the cycle the last byte is output, then go to IDLE. The next pop may not occur before that cycle.
- fififo_rd_en is never asserted while fififo_empty=1 or outside POP.
- Simultaneous events:
  - ack in the same cycle the timeout expires counts as ack.
  - ch_type_tbl/ch_type_en changes after CHK do not affect the current frame.

Optional Feature:
- Macro PC_RX_DISPATCH_STAT_EN.
- Defined: frame_cnt increments on each out_eof. drop_cnt increments on each err_len/err_type/err_tmo pulse. Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: frame_cnt and drop_cnt are tied to 0 and no counter logic is built.

Test Plan:
- Desc type 0x0003, tbl[1]=0x0003 enabled, len=20, start=0x100, ack after 2 cycles -> addr 0x100..0x106 read; 4 bytes (idx 3..6) on out_valid=4'b0010; sof on idx3, eof on idx6; one done pulse.
- len=16 (N=3 <= HDR_SKIP) and len=5000 -> err_len pulse each; fdram_rd_req never asserted; next desc processed.
- Type 0x00FF with no enabled match -> err_type pulse, no req; same type with tbl[0]=tbl[2]=0x00FF -> channel 0 receives data.
- Ack withheld -> req high exactly ACK_TMO cycles, then err_tmo pulse; ack on final cycle -> frame proceeds normally.
- start=0xFFE, len=18 -> addr sequence 0xFFE,0xFFF,0x000,0x001,0x002; two back-to-back desc in FIFO -> second pop only after first done.
- With STAT_EN: 3 good + 2 dropped frames -> frame_cnt=3, drop_cnt=2; reset asserted mid-RD -> all outputs 0 at once.
